dac_spi_tx: RTL and testbench

//  SPI master transmitter driving a 12-bit serial DAC (LTC2630/AD5621-class) from the clk_100 domain.

---
 rtl/dac_spi_pkg.sv | 26 ++
 rtl/dac_spi_tx_sck_gen.sv | 43 ++++
 rtl/dac_spi_tx.sv | 177 +++++++++++++++++
 tb/tb_dac_spi_tx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_pkg.sv
// Shared definitions for dac_spi_tx: FSM state type, default frame geometry and DAC command codes.
package dac_spi_pkg;

  localparam int unsigned DAC_DATA_W  = 12;
  localparam int unsigned DAC_CMD_W   = 4;
  localparam int unsigned DAC_FRAME_W = DAC_CMD_W + DAC_DATA_W;

  localparam logic [DAC_CMD_W-1:0] CMD_WRITE_UPDATE = 4'h3;
  localparam logic [DAC_CMD_W-1:0] CMD_WRITE_INPUT  = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } dac_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dac_spi_tx_sck_gen.sv
// spi_sck_gen: free-running sck phase generator while run is high; sck idles low otherwise.
// rise_c/fall_c flag the cycle before sck goes high/low.
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_100,
  input  logic reset,
  input  logic run,
  output logic sck,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic             sck_nxt;
  logic             phase_end;

  always_ff @(posedge clk_100) begin
    if (reset) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else begin
      div_cnt <= div_cnt_nxt;
      sck     <= sck_nxt;
    end
  end

  always_comb begin
    div_cnt_nxt = '0;
    sck_nxt     = 1'b0;
    phase_end   = run && (div_cnt == DIV_LAST);
    rise_c      = phase_end && !sck;
    fall_c      = phase_end && sck;
    if (run) begin
      div_cnt_nxt = phase_end ? '0 : div_cnt + DIV_W'(1);
      sck_nxt     = phase_end ? !sck : sck;
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: SPI mode-0 transmitter framing {CMD, sample} MSB-first to a 12-bit serial DAC.
// Define DAC_LDAC_EN to build the ldac_n load strobe pulsed after each frame.
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int unsigned DATA_W   = DAC_DATA_W,
  parameter int unsigned CMD_W    = DAC_CMD_W,
`ifdef DAC_LDAC_EN
  parameter logic [CMD_W-1:0] CMD = CMD_W'(CMD_WRITE_INPUT),
`else
  parameter logic [CMD_W-1:0] CMD = CMD_W'(CMD_WRITE_UPDATE),
`endif
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned GAP      = 4,
  parameter int unsigned LDAC_W   = 2
) (
  input  logic              clk_100,
  input  logic              reset,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din_data,
  output logic              din_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              sck,
  output logic              cs_n,
  output logic              sdi,
  output logic              ldac_n
);

  localparam int unsigned FRAME_W = CMD_W + DATA_W;
  localparam int unsigned BIT_W   = $clog2(FRAME_W + 1);
  localparam int unsigned CNT_W   = $clog2(max3(CS_SETUP, CS_HOLD, GAP) + 1);

  localparam logic [BIT_W-1:0] BITS_ALL   = BIT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  // The IDLE accept cycle is the last cs_n-high cycle of the gap.
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 2);

  if (CLK_DIV == 0 || CS_SETUP == 0 || CS_HOLD == 0 || GAP < 2 || GAP < LDAC_W + 1)
  begin : g_cfg_check
    $error("dac_spi_tx: invalid timing parameters");
  end

  dac_state_e         state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [BIT_W-1:0]   bits_left, bits_left_nxt;
  logic [FRAME_W-1:0] shreg, shreg_nxt;
  logic               in_frame_nxt;
  logic               accept_c;
  logic               rise_c, fall_c;

  assign accept_c = din_valid && din_ready;

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk_100(clk_100),
    .reset  (reset),
    .run    (state == ST_SHIFT),
    .sck    (sck),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  always_ff @(posedge clk_100) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bits_left  <= '0;
      shreg      <= '0;
      din_ready  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cs_n       <= 1'b1;
      sdi        <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bits_left  <= bits_left_nxt;
      shreg      <= shreg_nxt;
      din_ready  <= (state_nxt == ST_IDLE);
      busy       <= (state_nxt != ST_IDLE);
      frame_done <= (state == ST_HOLD) && (state_nxt == ST_GAP);
      cs_n       <= !in_frame_nxt;
      sdi        <= in_frame_nxt ? shreg_nxt[FRAME_W-1] : 1'b0;
    end
  end

  // Next-state: bits_left counts sck rises still owed; the final fall ends the shift phase.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bits_left_nxt = bits_left;
    shreg_nxt     = shreg;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          state_nxt     = ST_SETUP;
          cnt_nxt       = '0;
          bits_left_nxt = BITS_ALL;
          shreg_nxt     = {CMD, din_data};
        end
      end
      ST_SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nxt = ST_SHIFT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (rise_c) begin
          bits_left_nxt = bits_left - BIT_W'(1);
        end
        if (fall_c) begin
          if (bits_left == '0) begin
            state_nxt = ST_HOLD;
            cnt_nxt   = '0;
          end else begin
            shreg_nxt = shreg << 1;
          end
        end
      end
      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = ST_GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    in_frame_nxt = (state_nxt == ST_SETUP) || (state_nxt == ST_SHIFT) || (state_nxt == ST_HOLD);
  end

`ifdef DAC_LDAC_EN
  localparam int unsigned LDAC_CNT_W = $clog2(LDAC_W + 1);

  logic [LDAC_CNT_W-1:0] ldac_cnt, ldac_cnt_nxt;

  always_ff @(posedge clk_100) begin
    if (reset) begin
      ldac_cnt <= '0;
      ldac_n   <= 1'b1;
    end else begin
      ldac_cnt <= ldac_cnt_nxt;
      ldac_n   <= (ldac_cnt_nxt == '0);
    end
  end

  // Load pulse starts the cycle after frame_done and runs LDAC_W cycles.
  always_comb begin
    ldac_cnt_nxt = ldac_cnt;
    if (frame_done) begin
      ldac_cnt_nxt = LDAC_CNT_W'(LDAC_W);
    end else if (ldac_cnt != '0) begin
      ldac_cnt_nxt = ldac_cnt - LDAC_CNT_W'(1);
    end
  end
`else
  assign ldac_n = 1'b1;
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: directed and random frames on a CLK_DIV=2 and a CLK_DIV=1 instance,
// checked against frame timing and bit content computed from the protocol rules.
module tb_dac_spi_tx;

  localparam int unsigned CS_SETUP = 2;
  localparam int unsigned CS_HOLD  = 2;
  localparam int unsigned GAP      = 4;
  localparam int unsigned LDAC_W   = 2;
  localparam int unsigned FRAME_W  = 16;
`ifdef DAC_LDAC_EN
  localparam logic [3:0] CMD     = 4'h0;
  localparam int         LDAC_ON = 1;
`else
  localparam logic [3:0] CMD     = 4'h3;
  localparam int         LDAC_ON = 0;
`endif

  logic        clk_100 = 1'b0;
  logic        reset;
  logic        v0, v1;
  logic [11:0] d0, d1;
  logic        r0, b0, fd0, sck0, cs0, sdi0, ld0;
  logic        r1, b1, fd1, sck1, cs1, sdi1, ld1;
  logic        m_ready, m_busy, m_fd, m_sck, m_cs_n, m_sdi, m_ldac_n;
  bit          sel;
  int          cyc = 0;
  int          acc_cyc;
  int          checks = 0;
  int          failures = 0;

  always #5 clk_100 = ~clk_100;
  always @(posedge clk_100) cyc <= cyc + 1;

  dac_spi_tx u_dut0 (
    .clk_100(clk_100), .reset(reset), .din_valid(v0), .din_data(d0), .din_ready(r0),
    .busy(b0), .frame_done(fd0), .sck(sck0), .cs_n(cs0), .sdi(sdi0), .ldac_n(ld0)
  );

  dac_spi_tx #(.CLK_DIV(1)) u_dut1 (
    .clk_100(clk_100), .reset(reset), .din_valid(v1), .din_data(d1), .din_ready(r1),
    .busy(b1), .frame_done(fd1), .sck(sck1), .cs_n(cs1), .sdi(sdi1), .ldac_n(ld1)
  );

  always_comb begin
    m_ready  = sel ? r1   : r0;
    m_busy   = sel ? b1   : b0;
    m_fd     = sel ? fd1  : fd0;
    m_sck    = sel ? sck1 : sck0;
    m_cs_n   = sel ? cs1  : cs0;
    m_sdi    = sel ? sdi1 : sdi0;
    m_ldac_n = sel ? ld1  : ld0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (sel) v1 = v; else v0 = v;
  endtask

  task automatic set_data(input logic [11:0] d);
    if (sel) d1 = d; else d0 = d;
  endtask

  task automatic step();
    @(posedge clk_100);
    #1;
  endtask

  // Offer d, capture the whole frame, compare against timing/content derived from div.
  task automatic run_frame(input logic [11:0] d, input logic [11:0] nd, input bit hold,
                           input bit toggle, input int div);
    int n, idx, cs_low, rises, fd_cnt, fd_idx, ready_idx, busy_cnt, ld_cnt, ld_first, first_rise;
    int cs_exp;
    logic [15:0] bits, word;
    logic prev_sck;
    word = {CMD, d};
    cs_exp = CS_SETUP + 2 * div * FRAME_W + CS_HOLD;
    {cs_low, rises, fd_cnt, fd_idx, ready_idx, busy_cnt, ld_cnt, ld_first, first_rise} = '0;
    bits = '0;
    prev_sck = 1'b0;
    set_data(d);
    set_valid(1'b1);
    n = 0;
    while (m_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("accept_wait", 32'(n < 200), 32'd1);
    acc_cyc = cyc;
    step();
    if (!hold) set_valid(1'b0);
    set_data(nd);
    for (idx = 1; idx <= 200; idx++) begin
      if (toggle) set_data(12'($urandom));
      if (m_cs_n === 1'b0) cs_low++;
      if (m_sck === 1'b1 && prev_sck === 1'b0) begin
        if (rises == 0) first_rise = idx;
        if (rises < 16) bits = {bits[14:0], m_sdi};
        rises++;
      end
      if (m_fd === 1'b1) begin
        fd_cnt++;
        fd_idx = idx;
      end
      if (m_busy === 1'b1) busy_cnt++;
      if (m_ldac_n === 1'b0) begin
        if (ld_cnt == 0) ld_first = idx;
        ld_cnt++;
      end
      if (m_ready === 1'b1) begin
        ready_idx = idx;
        break;
      end
      prev_sck = m_sck;
      step();
    end
    check("cs_low_cycles", 32'(cs_low), 32'(cs_exp));
    check("sck_rises", 32'(rises), 32'(FRAME_W));
    check("sdi_word", 32'(bits), 32'(word));
    check("first_rise", 32'(first_rise), 32'(1 + CS_SETUP + div));
    check("frame_done_cnt", 32'(fd_cnt), 32'd1);
    check("frame_done_at", 32'(fd_idx), 32'(cs_exp + 1));
    check("ready_return", 32'(ready_idx), 32'(cs_exp + GAP));
    check("busy_cycles", 32'(busy_cnt), 32'(cs_exp + GAP - 1));
    check("ldac_low_cnt", 32'(ld_cnt), 32'(LDAC_ON * LDAC_W));
    check("ldac_first", 32'(ld_first), 32'(LDAC_ON * (cs_exp + 2)));
  endtask

  initial begin
    int a1, n, rises, fd_seen, cs_seen;
    logic prev;
    reset = 1'b1;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
    sel = 1'b0;

    // Reset state
    step();
    check("rst_ready", 32'(r0), 32'd0);
    check("rst_busy", 32'(b0), 32'd0);
    check("rst_frame_done", 32'(fd0), 32'd0);
    check("rst_sck", 32'(sck0), 32'd0);
    check("rst_cs_n", 32'(cs0), 32'd1);
    check("rst_sdi", 32'(sdi0), 32'd0);
    check("rst_ldac_n", 32'(ld0), 32'd1);
    reset = 1'b0;
    step();
    check("ready_after_rst", 32'(r0), 32'd1);

    // Directed sample
    run_frame(12'hA5C, 12'h000, 1'b0, 1'b0, 2);

    // Back-to-back with valid held high
    run_frame(12'h000, 12'hFFF, 1'b1, 1'b0, 2);
    a1 = acc_cyc;
    run_frame(12'hFFF, 12'($urandom), 1'b0, 1'b0, 2);
    check("b2b_spacing", 32'(acc_cyc - a1), 32'(CS_SETUP + 4 * FRAME_W + CS_HOLD + GAP));

    // Random samples, one with din_data churning during the frame
    run_frame(12'($urandom), 12'($urandom), 1'b0, 1'b1, 2);
    for (int i = 0; i < 2; i++) run_frame(12'($urandom), 12'($urandom), 1'b0, 1'b0, 2);

    // CLK_DIV=1 instance
    sel = 1'b1;
    run_frame(12'h001, 12'h000, 1'b0, 1'b0, 1);
    run_frame(12'($urandom), 12'($urandom), 1'b0, 1'b1, 1);
    sel = 1'b0;

    // Reset mid-frame at the 8th sck rise
    set_data(12'($urandom));
    set_valid(1'b1);
    n = 0;
    while (r0 !== 1'b1 && n < 200) begin step(); n++; end
    step();
    set_valid(1'b0);
    rises = 0;
    prev = 1'b0;
    n = 0;
    while (rises < 8 && n < 200) begin
      if (sck0 === 1'b1 && prev === 1'b0) rises++;
      prev = sck0;
      if (rises < 8) begin step(); n++; end
    end
    check("rise8_reached", 32'(rises), 32'd8);
    reset = 1'b1;
    step();
    check("midrst_cs_n", 32'(cs0), 32'd1);
    check("midrst_sck", 32'(sck0), 32'd0);
    check("midrst_busy", 32'(b0), 32'd0);
    check("midrst_frame_done", 32'(fd0), 32'd0);
    reset = 1'b0;
    fd_seen = 0;
    cs_seen = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (fd0 === 1'b1) fd_seen++;
      if (cs0 === 1'b0) cs_seen++;
    end
    check("abandoned_no_done", 32'(fd_seen), 32'd0);
    check("abandoned_cs_idle", 32'(cs_seen), 32'd0);
    run_frame(12'($urandom), 12'($urandom), 1'b0, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
